// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath width, complex sample type and the
// bit-reversal helper used by the output reorder buffer.
package fft_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int BITREV_W = 16;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] re;
      logic [DATA_WIDTH-1:0] im;
   } complex_t;

   typedef enum logic {
      RD_IDLE,
      RD_READ
   } rd_state_t;

   // Reverse the low n bits of addr; bits at and above n come back zero.
   function automatic logic [BITREV_W-1:0] bitrev(
      input logic [BITREV_W-1:0] addr,
      input logic [4:0]          n
   );
      logic [BITREV_W-1:0] r;
      logic [3:0]          src;
      r = '0;
      for (int i = 0; i < BITREV_W; i++) begin
         if (i < int'(n)) begin
            src  = 4'(int'(n) - 1 - i);
            r[i] = addr[src];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: simple dual-port RAM holding both ping-pong banks,
// one write port and one registered read port.
module fft_reorder_bank #(
   parameter int ADDR_W = 11,
   parameter int WIDTH  = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: bit-reversed to natural order ping-pong buffer with
// per-frame size; FFT_REORDER_OVF_EN adds the sticky ovf output.
module fft_reorder #(
   parameter int FFT_SIZE   = 1024,
   parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
   parameter int LOG2_SIZE  = $clog2(FFT_SIZE)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DATA_WIDTH-1:0]              din_re,
   input  logic [DATA_WIDTH-1:0]              din_im,
   input  logic                               din_valid,
   input  logic [$clog2(LOG2_SIZE+1)-1:0]     nfft_log2,
   output logic [DATA_WIDTH-1:0]              dout_re,
   output logic [DATA_WIDTH-1:0]              dout_im,
   output logic                               dout_valid,
   output logic                               dout_last
`ifdef FFT_REORDER_OVF_EN
   ,
   output logic                               ovf
`endif
);

   import fft_pkg::*;

   localparam int NB = $clog2(LOG2_SIZE + 1);
   localparam int WW = 2 * DATA_WIDTH;

   rd_state_t            state_q, state_d;
   logic [1:0]           full_q, set_v, clr_v;
   logic [NB-1:0]        bank_n_q [2];
   logic                 wr_bank_q, rd_bank_q, rd_bank_d;
   logic [LOG2_SIZE-1:0] wr_cnt_q, rd_cnt_q, rd_cnt_d;
   logic [NB-1:0]        n_in, n_w, n_r;
   logic [LOG2_SIZE-1:0] wr_max, rd_max, wr_addr;
   logic                 accept, wr_last, rd_en, rd_last;
   logic [WW-1:0]        rd_data;
   logic                 rd_v1, rd_l1;

   always_comb begin
      n_in = nfft_log2;
      if (nfft_log2 == '0)
         n_in = NB'(1);
      else if (nfft_log2 > NB'(LOG2_SIZE))
         n_in = NB'(LOG2_SIZE);
   end

   // A bank being drained in this cycle is already free to the writer,
   // which keeps continuous input at a fixed size from ever overrunning.
   always_comb begin
      n_w     = (wr_cnt_q == '0) ? n_in : bank_n_q[wr_bank_q];
      wr_max  = ~({LOG2_SIZE{1'b1}} << n_w);
      wr_last = (wr_cnt_q == wr_max);
      wr_addr = LOG2_SIZE'(bitrev(BITREV_W'(wr_cnt_q), 5'(n_w)));
      accept  = din_valid &&
                !(full_q[wr_bank_q] && !clr_v[wr_bank_q]);
      set_v   = '0;
      if (accept && wr_last) set_v[wr_bank_q] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
      clr_v     = '0;
      rd_en     = 1'b0;
      rd_last   = 1'b0;
      n_r       = bank_n_q[rd_bank_q];
      rd_max    = ~({LOG2_SIZE{1'b1}} << n_r);
      unique case (state_q)
         RD_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = RD_READ;
               rd_cnt_d = '0;
            end
         end
         RD_READ: begin
            rd_en    = 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == rd_max) begin
               rd_last          = 1'b1;
               clr_v[rd_bank_q] = 1'b1;
               rd_bank_d        = !rd_bank_q;
               rd_cnt_d         = '0;
               // Chain straight into the other bank when it is waiting.
               if (!full_q[!rd_bank_q]) state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RD_IDLE;
         full_q      <= '0;
         bank_n_q[0] <= '0;
         bank_n_q[1] <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         full_q    <= (full_q & ~clr_v) | set_v;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;
         if (accept) begin
            if (wr_cnt_q == '0) bank_n_q[wr_bank_q] <= n_in;
            if (wr_last) begin
               wr_cnt_q  <= '0;
               wr_bank_q <= !wr_bank_q;
            end else begin
               wr_cnt_q <= wr_cnt_q + 1'b1;
            end
         end
      end
   end

   fft_reorder_bank #(
      .ADDR_W(LOG2_SIZE + 1),
      .WIDTH (WW)
   ) u_bank (
      .clk  (clk),
      .we   (accept),
      .waddr({wr_bank_q, wr_addr}),
      .wdata({din_re, din_im}),
      .raddr({rd_bank_q, rd_cnt_q}),
      .rdata(rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v1      <= 1'b0;
         rd_l1      <= 1'b0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         dout_re    <= '0;
         dout_im    <= '0;
      end else begin
         rd_v1      <= rd_en;
         rd_l1      <= rd_last;
         dout_valid <= rd_v1;
         dout_last  <= rd_l1;
         if (rd_v1) begin
            dout_re <= rd_data[WW-1 -: DATA_WIDTH];
            dout_im <= rd_data[DATA_WIDTH-1:0];
         end
      end
   end

`ifdef FFT_REORDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (din_valid && !accept)
         ovf <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: directed and randomized checks of fft_reorder against
// a frame-level model; ovf is checked when FFT_REORDER_OVF_EN is set.
`timescale 1ns/1ps
module tb_fft_reorder;
   import fft_pkg::*;

   localparam int FFT_SIZE = 16;
   localparam int LOG2     = 4;
   localparam int NB       = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic [DATA_WIDTH-1:0] din_re = '0, din_im = '0;
   logic                  din_valid = 1'b0;
   logic [NB-1:0]         nfft_log2 = '0;
   logic [DATA_WIDTH-1:0] dout_re, dout_im;
   logic                  dout_valid, dout_last;
`ifdef FFT_REORDER_OVF_EN
   logic                  ovf;
`endif

   fft_reorder #(.FFT_SIZE(FFT_SIZE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_re    (din_re),
      .din_im    (din_im),
      .din_valid (din_valid),
      .nfft_log2 (nfft_log2),
      .dout_re   (dout_re),
      .dout_im   (dout_im),
      .dout_valid(dout_valid),
      .dout_last (dout_last)
`ifdef FFT_REORDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Frame-level model: two banks stored in natural order.
   typedef struct packed {
      complex_t d;
      logic     last;
   } exp_t;

   exp_t     exp_q[$];
   complex_t m_mem [2][FFT_SIZE];
   bit       m_full [2];
   int       m_n [2];
   int       m_wb, m_wc, m_cur_n, m_rb, m_left, m_drops;
   bit       m_busy, m_ovf;

   function automatic int clampn(input int n);
      if (n == 0) return 1;
      if (n > LOG2) return LOG2;
      return n;
   endfunction

   function automatic int rev(input int a, input int n);
      int r = 0;
      for (int i = 0; i < n; i++)
         if (((a >> i) & 1) != 0) r = r | (1 << (n - 1 - i));
      return r;
   endfunction

   task automatic model_reset();
      m_full[0] = 0; m_full[1] = 0;
      m_wb = 0; m_wc = 0; m_rb = 0; m_left = 0;
      m_busy = 0; m_ovf = 0; m_cur_n = 1;
      exp_q.delete();
   endtask

   task automatic model_cycle(input bit v, input complex_t w, input int n);
      bit old_full [2];
      int clr;
      bit start;
      exp_t e;
      old_full = m_full;
      clr = -1;
      start = 0;
      if (m_busy) begin
         if (m_left == 1) begin
            clr = m_rb;
            m_rb = 1 - m_rb;
            if (old_full[m_rb]) start = 1;
            else m_busy = 0;
         end else begin
            m_left--;
         end
      end else if (old_full[m_rb]) begin
         start = 1;
      end
      if (v) begin
         if (old_full[m_wb] && clr != m_wb) begin
            m_drops++;
            m_ovf = 1;
         end else begin
            if (m_wc == 0) m_cur_n = clampn(n);
            m_mem[m_wb][rev(m_wc, m_cur_n)] = w;
            if (m_wc == (1 << m_cur_n) - 1) begin
               m_full[m_wb] = 1;
               m_n[m_wb] = m_cur_n;
               m_wb = 1 - m_wb;
               m_wc = 0;
            end else begin
               m_wc++;
            end
         end
      end
      if (clr >= 0) m_full[clr] = 0;
      if (start) begin
         m_busy = 1;
         m_left = 1 << m_n[m_rb];
         for (int k = 0; k < m_left; k++) begin
            e.d = m_mem[m_rb][k];
            e.last = (k == m_left - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic step(input bit v, input logic [DATA_WIDTH-1:0] re,
                       input logic [DATA_WIDTH-1:0] im, input int n);
      complex_t w;
      din_valid = v;
      din_re = re;
      din_im = im;
      nfft_log2 = NB'(n);
      w.re = re;
      w.im = im;
      @(posedge clk);
      model_cycle(v, w, n);
      @(negedge clk);
   endtask

   // Output log and per-cycle comparison against the model.
   int log_re[$];
   bit log_last[$];
   int log_cyc[$];
   bit mid = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         mid = 0;
      end else begin
         if (dout_valid === 1'b1) begin
            log_re.push_back(int'(dout_re));
            log_last.push_back(dout_last);
            log_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected dout_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("dout_re", dout_re, e.d.re);
               check("dout_im", dout_im, e.d.im);
               check("dout_last", dout_last, e.last);
               mid = !e.last;
            end
         end else if (mid) begin
            check("gap inside frame", dout_valid, 1);
            mid = 0;
         end
`ifdef FFT_REORDER_OVF_EN
         check("ovf", ovf, m_ovf);
`endif
      end
   end

   int vals[16];
   int x_re[$];
   bit x_last[$];

   task automatic send_vals(input int n, input int len);
      for (int i = 0; i < len; i++)
         step(1, DATA_WIDTH'(vals[i]), DATA_WIDTH'(-vals[i]), n);
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || m_busy || m_full[0] || m_full[1] ||
              dout_valid) && k < 300) begin
         step(0, '0, '0, 0);
         k++;
      end
      check("drain within budget", k < 300, 1);
      repeat (3) step(0, '0, '0, 0);
   endtask

   task automatic clear_log();
      log_re.delete();
      log_last.delete();
      log_cyc.delete();
      x_re.delete();
      x_last.delete();
   endtask

   task automatic expect_frame(input int len);
      for (int i = 0; i < len; i++) begin
         x_re.push_back(i);
         x_last.push_back(i == len - 1);
      end
   endtask

   task automatic cmp_log(input string name);
      check({name, " count"}, log_re.size(), x_re.size());
      for (int i = 0; i < x_re.size() && i < log_re.size(); i++) begin
         check({name, " re"}, log_re[i], x_re[i]);
         check({name, " last"}, log_last[i], x_last[i]);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("reset dout_valid", dout_valid, 0);
      check("reset dout_last", dout_last, 0);
      check("reset dout_re", dout_re, 0);
      check("reset dout_im", dout_im, 0);
`ifdef FFT_REORDER_OVF_EN
      check("reset ovf", ovf, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int b8[8];
      int cap, k, nlast;
      b8 = '{0, 4, 2, 6, 1, 5, 3, 7};
      m_drops = 0;
      #1;
      @(negedge clk);
      do_reset();
      repeat (2) step(0, '0, '0, 0);

      // Basic reorder and latency.
      clear_log();
      for (int i = 0; i < 8; i++) vals[i] = b8[i];
      send_vals(3, 8);
      cap = cyc;
      drain();
      expect_frame(8);
      cmp_log("basic");
      if (log_cyc.size() == 8) begin
         check("first valid latency", log_cyc[0] - cap, 3);
         check("contiguous span", log_cyc[7] - log_cyc[0], 7);
      end else begin
         check("basic output present", log_cyc.size(), 8);
      end

      // Run-time size change.
      clear_log();
      vals[0] = 0; vals[1] = 2; vals[2] = 1; vals[3] = 3;
      send_vals(2, 4);
      for (int i = 0; i < 8; i++) vals[i] = b8[i];
      send_vals(3, 8);
      drain();
      expect_frame(4);
      expect_frame(8);
      cmp_log("size change");

      // Clamping low and high.
      clear_log();
      vals[0] = 0; vals[1] = 1;
      send_vals(0, 2);
      for (int i = 0; i < 16; i++) vals[i] = rev(i, 4);
      send_vals(7, 16);
      drain();
      expect_frame(2);
      expect_frame(16);
      cmp_log("clamp");

      // Continuous streaming, four frames.
      clear_log();
      m_drops = 0;
      for (int f = 0; f < 4; f++)
         for (int i = 0; i < 8; i++)
            step(1, DATA_WIDTH'($urandom), DATA_WIDTH'($urandom), 3);
      drain();
      check("stream count", log_re.size(), 32);
      check("stream drops", m_drops, 0);
      nlast = 0;
      foreach (log_last[i]) nlast += int'(log_last[i]);
      check("stream frame ends", nlast, 4);
`ifdef FFT_REORDER_OVF_EN
      check("stream ovf", ovf, 0);
`endif

      // Overrun: long frame, then short frames pile up behind it.
      clear_log();
      for (int i = 0; i < 16; i++)
         step(1, DATA_WIDTH'($urandom), DATA_WIDTH'($urandom), 4);
      for (int i = 0; i < 6; i++)
         step(1, DATA_WIDTH'(500 + i), DATA_WIDTH'(i), 1);
      drain();
      check("overrun count", log_re.size(), 18);
      if (log_re.size() == 18) begin
         check("overrun kept first", log_re[16], 500);
         check("overrun kept second", log_re[17], 501);
      end
`ifdef FFT_REORDER_OVF_EN
      check("overrun ovf", ovf, 1);
      repeat (10) step(0, '0, '0, 0);
      check("overrun ovf sticky", ovf, 1);
`endif

      // Randomized traffic with random sizes and valid gaps.
      for (int i = 0; i < 1500; i++)
         step(($urandom % 5) != 0, DATA_WIDTH'($urandom),
              DATA_WIDTH'($urandom), int'($urandom % 8));
      drain();

      // Reset during sample 5 of a write.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, DATA_WIDTH'(90 + i), '0, 3);
      din_valid = 1'b1;
      din_re = DATA_WIDTH'(94);
      do_reset();
      clear_log();
      for (int i = 0; i < 8; i++) vals[i] = b8[i];
      send_vals(3, 8);
      drain();
      expect_frame(8);
      cmp_log("after write reset");

      // Reset during a read.
      for (int i = 0; i < 16; i++)
         step(1, DATA_WIDTH'(100 + i), DATA_WIDTH'(7), 4);
      k = 0;
      while (dout_valid !== 1'b1 && k < 50) begin
         step(0, '0, '0, 0);
         k++;
      end
      check("read started", dout_valid, 1);
      step(0, '0, '0, 0);
      do_reset();
      repeat (3) step(0, '0, '0, 0);
      check("idle after read reset", dout_valid, 0);
      clear_log();
      for (int i = 0; i < 8; i++) vals[i] = b8[i];
      send_vals(3, 8);
      drain();
      expect_frame(8);
      cmp_log("after read reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: bench did not finish");
      $fatal(1);
   end

endmodule
